// File: rtl/cdr_pkg.sv
// Shared encodings for the CDR loop-gain sequencer: FSM states, gain codes,
// phase-detector vote codes.
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_TRACK  = 2'd3
  } cdr_state_t;

  localparam logic [1:0] GAIN_X4 = 2'd2;
  localparam logic [1:0] GAIN_X2 = 2'd1;
  localparam logic [1:0] GAIN_X1 = 2'd0;

  localparam logic [1:0] PHE_NONE = 2'b00;
  localparam logic [1:0] PHE_UP   = 2'b01;
  localparam logic [1:0] PHE_DN   = 2'b10;
  localparam logic [1:0] PHE_BOTH = 2'b11;

  function automatic logic [1:0] gain_for(input cdr_state_t s);
    case (s)
      ST_SETTLE: return GAIN_X2;
      ST_TRACK:  return GAIN_X1;
      default:   return GAIN_X4;
    endcase
  endfunction

endpackage

// File: rtl/cdr_win_acc.sv
// Fixed-length observation window: counts cycles, accumulates signed
// phase-detector votes and flags good/bad windows on the last cycle.
module cdr_win_acc
  import cdr_pkg::*;
#(
  parameter int WIN_LEN    = 32,
  parameter int LOCK_THR   = 4,
  parameter int UNLOCK_THR = 16
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       run,
  input  logic       restart,
  input  logic [1:0] phe,
  output logic       win_end,
  output logic       good,
  output logic       bad
);

  localparam int CW = $clog2(WIN_LEN);
  localparam int NW = CW + 2;
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  logic        [CW-1:0] win_cnt;
  logic signed [NW-1:0] net;
  logic signed [NW-1:0] vote;
  logic signed [NW-1:0] net_final;
  logic        [NW-1:0] net_abs;

  always_comb begin
    vote = '0;
    case (phe)
      PHE_UP:  vote = NW'(1);
      PHE_DN:  vote = '1;
      default: vote = '0;
    endcase
  end

  // The final cycle's vote is part of the window being judged.
  assign net_final = net + vote;
  assign net_abs   = net_final[NW-1] ? $unsigned(-net_final) : $unsigned(net_final);
  assign win_end   = run && (win_cnt == LAST);
  assign good      = win_end && (net_abs <= NW'(LOCK_THR));
  assign bad       = win_end && (net_abs >  NW'(UNLOCK_THR));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      win_cnt <= '0;
      net     <= '0;
    end else if (restart || !run || win_end) begin
      win_cnt <= '0;
      net     <= '0;
    end else begin
      win_cnt <= win_cnt + CW'(1);
      net     <= net_final;
    end
  end

endmodule

// File: rtl/cdr_gear_ctrl.sv
// CDR loop-gain sequencer: steps gain ACQ -> SETTLE -> TRACK from window
// quality strobes. Optional lol_cnt output enabled by CDR_LOL_CNT_EN.
//
// state  | meaning
// IDLE   | loop disabled, gain x4, unlocked
// ACQ    | acquisition, gain x4, minimum window count enforced
// SETTLE | gain x2, waiting for LOCK_WINS consecutive good windows
// TRACK  | gain x1, locked; a bad window drops back to ACQ
module cdr_gear_ctrl
  import cdr_pkg::*;
#(
  parameter int WIN_LEN      = 32,
  parameter int ACQ_MIN_WINS = 4,
  parameter int LOCK_THR     = 4,
  parameter int LOCK_WINS    = 8,
  parameter int UNLOCK_THR   = 16
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       cdr_en,
  input  logic [1:0] phe,
  output logic [1:0] gain_sel,
  output logic       fi_clr,
  output logic       locked,
  output logic       lol_pulse,
  output logic [1:0] state
`ifdef CDR_LOL_CNT_EN
  ,
  output logic [7:0] lol_cnt
`endif
);

  localparam int AW = $clog2(ACQ_MIN_WINS + 1);
  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam logic [AW-1:0] ACQ_SAT   = AW'(ACQ_MIN_WINS);
  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_MIN_WINS - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WINS - 1);

  cdr_state_t    state_q, state_d;
  logic [AW-1:0] acq_wins_q, acq_wins_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          fi_clr_d, lol_d, restart;
  logic          win_end, good, bad;

  cdr_win_acc #(
    .WIN_LEN   (WIN_LEN),
    .LOCK_THR  (LOCK_THR),
    .UNLOCK_THR(UNLOCK_THR)
  ) u_win_acc (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .run    (state_q != ST_IDLE),
    .restart(restart),
    .phe    (phe),
    .win_end(win_end),
    .good   (good),
    .bad    (bad)
  );

  always_comb begin
    state_d    = state_q;
    acq_wins_d = acq_wins_q;
    good_cnt_d = good_cnt_q;
    fi_clr_d   = 1'b0;
    lol_d      = 1'b0;
    // Disable wins over any coincident window decision, strobes included.
    if (!cdr_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_ACQ;
          fi_clr_d = 1'b1;
        end
        ST_ACQ: if (win_end) begin
          if (acq_wins_q < ACQ_SAT) acq_wins_d = acq_wins_q + AW'(1);
          if (acq_wins_q >= ACQ_LAST && good) state_d = ST_SETTLE;
        end
        ST_SETTLE: if (win_end) begin
          if (bad) begin
            state_d  = ST_ACQ;
            fi_clr_d = 1'b1;
          end else if (good) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_q >= GOOD_LAST) state_d = ST_TRACK;
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_TRACK: if (win_end && bad) begin
          state_d  = ST_ACQ;
          fi_clr_d = 1'b1;
          lol_d    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    restart = (state_d != state_q) || (state_d == ST_IDLE);
    if (restart) begin
      acq_wins_d = '0;
      good_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      acq_wins_q <= '0;
      good_cnt_q <= '0;
      gain_sel   <= GAIN_X4;
      fi_clr     <= 1'b0;
      locked     <= 1'b0;
      lol_pulse  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acq_wins_q <= acq_wins_d;
      good_cnt_q <= good_cnt_d;
      gain_sel   <= gain_for(state_d);
      fi_clr     <= fi_clr_d;
      locked     <= (state_d == ST_TRACK);
      lol_pulse  <= lol_d;
    end
  end

  assign state = state_q;

`ifdef CDR_LOL_CNT_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      lol_cnt <= '0;
    else if (lol_d && lol_cnt != 8'hFF)
      lol_cnt <= lol_cnt + 8'd1;
  end
`endif

endmodule
